// File: rtl/csr_port_arbiter_pkg.sv
// Shared types and encodings for the CSR port arbiter.
// Owner codes double as requester indices; OWN_NONE marks "no grantee yet".
package csr_port_arbiter_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int BUS_W      = 64;

  localparam logic [1:0] OWN_EXC  = 2'd0;
  localparam logic [1:0] OWN_EXE  = 2'd1;
  localparam logic [1:0] OWN_IRQ  = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  lock;
    logic [CSR_ADDR_W-1:0] addr;
    logic                  ren;
    logic                  wen;
    logic [BUS_W-1:0]      wdata;
  } csr_req_t;

  function automatic logic [2:0] own_mask(input logic [1:0] own);
    logic [2:0] m;
    m = 3'b000;
    case (own)
      OWN_EXC: m = 3'b001;
      OWN_EXE: m = 3'b010;
      OWN_IRQ: m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/csr_port_arbiter_pick.sv
// Combinational grant selection: lock restricts eligibility to the owner, otherwise
// fixed priority 0 > 1 > 2, with requester 2 lifted above 1 while promoted.
module csr_port_arbiter_pick
  import csr_port_arbiter_pkg::*;
(
  input  logic [2:0] valid_i,
  input  logic       lock_i,
  input  logic [1:0] owner_i,
  input  logic       promote_i,
  output logic       gnt_vld_o,
  output logic [1:0] gnt_idx_o
);

  logic [2:0] elig;

  always_comb begin
    elig = valid_i;
    if (lock_i) begin
      elig = valid_i & own_mask(owner_i);
    end

    gnt_vld_o = |elig;
    gnt_idx_o = OWN_NONE;
    if (elig[0]) begin
      gnt_idx_o = OWN_EXC;
    end else if (promote_i && elig[2]) begin
      gnt_idx_o = OWN_IRQ;
    end else if (elig[1]) begin
      gnt_idx_o = OWN_EXE;
    end else if (elig[2]) begin
      gnt_idx_o = OWN_IRQ;
    end
  end

endmodule

// File: rtl/csr_port_arbiter.sv
// Serialises three requesters onto one CSR file port; 3 cycles per access
// (grant, one-cycle enables, one-cycle ack); requesters hold valid until ack.
module csr_port_arbiter
  import csr_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  input  logic        req0_lock,
  input  logic [11:0] req0_addr,
  input  logic        req0_ren,
  input  logic        req0_wen,
  input  logic [63:0] req0_wdata,
  output logic        req0_ack,
  output logic [63:0] req0_rdata,

  input  logic        req1_valid,
  input  logic        req1_lock,
  input  logic [11:0] req1_addr,
  input  logic        req1_ren,
  input  logic        req1_wen,
  input  logic [63:0] req1_wdata,
  output logic        req1_ack,
  output logic [63:0] req1_rdata,

  input  logic        req2_valid,
  input  logic        req2_lock,
  input  logic [11:0] req2_addr,
  input  logic        req2_ren,
  input  logic        req2_wen,
  input  logic [63:0] req2_wdata,
  output logic        req2_ack,
  output logic [63:0] req2_rdata,

  output logic [11:0] o_csr_addr,
  output logic        o_csr_ren,
  output logic        o_csr_wen,
  output logic [63:0] o_csr_wdata,
  input  logic [63:0] i_csr_rdata,

  output logic        o_busy,
  output logic [1:0]  o_owner
);

  arb_state_e            state_q, state_d;
  logic                  lock_q, lock_d;
  logic [1:0]            owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CSR_ADDR_W-1:0] csr_addr_q, csr_addr_d;
  logic                  csr_ren_q, csr_ren_d;
  logic                  csr_wen_q, csr_wen_d;
  logic [BUS_W-1:0]      csr_wdata_q, csr_wdata_d;
  logic [2:0]            ack_q, ack_d;
  logic [BUS_W-1:0]      rdata_q [3];
  logic [BUS_W-1:0]      rdata_d [3];
  logic                  busy_q, busy_d;

  logic [2:0] req_valid;
  logic [2:0] req_lock;
  csr_req_t   req [3];
  csr_req_t   gnt_req;
  logic       own_lock;
  logic       promote;
  logic       gnt_vld;
  logic [1:0] gnt_idx;

  assign req_valid = {req2_valid, req1_valid, req0_valid};
  assign req_lock  = {req2_lock, req1_lock, req0_lock};
  assign req[0]    = {req0_lock, req0_addr, req0_ren, req0_wen, req0_wdata};
  assign req[1]    = {req1_lock, req1_addr, req1_ren, req1_wen, req1_wdata};
  assign req[2]    = {req2_lock, req2_addr, req2_ren, req2_wen, req2_wdata};

  // Lock only survives while the owner keeps its own lock input asserted.
  assign own_lock = lock_q && (|(req_lock & own_mask(owner_q)));
  assign promote  = (cnt_q == CNT_W'(STARVE_MAX));

  csr_port_arbiter_pick u_pick (
    .valid_i   (req_valid),
    .lock_i    (own_lock),
    .owner_i   (owner_q),
    .promote_i (promote),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    gnt_req = '0;
    case (gnt_idx)
      OWN_EXC: gnt_req = req[0];
      OWN_EXE: gnt_req = req[1];
      OWN_IRQ: gnt_req = req[2];
      default: gnt_req = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    csr_addr_d  = csr_addr_q;
    csr_ren_d   = csr_ren_q;
    csr_wen_d   = csr_wen_q;
    csr_wdata_d = csr_wdata_q;
    ack_d       = '0;
    rdata_d     = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        csr_ren_d = 1'b0;
        csr_wen_d = 1'b0;
        if (lock_q && !own_lock) begin
          lock_d = 1'b0;
        end
        if (!req_valid[2]) begin
          cnt_d = '0;
        end
        if (gnt_vld) begin
          state_d     = ST_ACCESS;
          owner_d     = gnt_idx;
          lock_d      = gnt_req.lock;
          csr_addr_d  = gnt_req.addr;
          csr_ren_d   = gnt_req.ren;
          csr_wen_d   = gnt_req.wen;
          csr_wdata_d = gnt_req.wdata;
          if (gnt_idx == OWN_IRQ) begin
            cnt_d = '0;
          end else if (gnt_idx == OWN_EXE && req_valid[2] && !promote) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ACCESS: begin
        csr_ren_d = 1'b0;
        csr_wen_d = 1'b0;
        // A no-op access leaves the requester's read data untouched.
        for (int i = 0; i < 3; i++) begin
          if (owner_q == 2'(i)) begin
            ack_d[i] = 1'b1;
            if (csr_ren_q || csr_wen_q) begin
              rdata_d[i] = i_csr_rdata;
            end
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || lock_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_q      <= 1'b0;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      csr_addr_q  <= '0;
      csr_ren_q   <= 1'b0;
      csr_wen_q   <= 1'b0;
      csr_wdata_q <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      csr_addr_q  <= csr_addr_d;
      csr_ren_q   <= csr_ren_d;
      csr_wen_q   <= csr_wen_d;
      csr_wdata_q <= csr_wdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 3; i++) begin
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  assign req0_ack    = ack_q[0];
  assign req1_ack    = ack_q[1];
  assign req2_ack    = ack_q[2];
  assign req0_rdata  = rdata_q[0];
  assign req1_rdata  = rdata_q[1];
  assign req2_rdata  = rdata_q[2];
  assign o_csr_addr  = csr_addr_q;
  assign o_csr_ren   = csr_ren_q;
  assign o_csr_wen   = csr_wen_q;
  assign o_csr_wdata = csr_wdata_q;
  assign o_busy      = busy_q;
  assign o_owner     = owner_q;

endmodule

// File: doc/csr_port_arbiter.md
Name: csr_port_arbiter

Overview:
- Shares the single CSR register-file access port between three requesters:
  - 0 = exception unit (trap entry/mret sequences)
  - 1 = execute-stage CSR instructions (csrrw/csrrs/...)
  - 2 = interrupt/timer status updater (mip)
- Sits between the requesters and the CSR file.
- Serialises accesses, returns read data with a one-cycle ack pulse, and lets a requester lock the port across multi-access sequences.

Parameters:
- STARVE_MAX, 8: number of consecutive lost arbitrations after which requester 2 is promoted above requester 1.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N=0,1,2) request pending; held until reqN_ack.
- reqN_lock  in  1  keep ownership after this access.
- reqN_addr  in  12  CSR address.
- reqN_ren  in  1  read.
- reqN_wen  in  1  write.
- reqN_wdata  in  64  write data.
- reqN_ack  out  1  one-cycle completion pulse.
- reqN_rdata  out  64  read data; valid while reqN_ack=1.
- o_csr_addr  out  12  CSR file address.
- o_csr_ren  out  1  CSR file read enable.
- o_csr_wen  out  1  CSR file write enable.
- o_csr_wdata  out  64  CSR file write data.
- i_csr_rdata  in  64  CSR file read data; combinational from o_csr_addr/o_csr_ren.
- o_busy  out  1  state != IDLE or lock held.
- o_owner  out  2  current/last grantee; 2'd3 = none.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-access):
  - o_csr_* = 0.
  - all reqN_ack = 0; all reqN_rdata = 0.
  - state = IDLE, lock = 0, owner = 3, starvation counter = 0, o_busy = 0.
- All outputs are registered.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Eligible set:
    - If lock is held: owner only, while owner's reqN_lock=1.
    - If the owner's lock drops, lock clears and all requesters are eligible in the same cycle.
  - Priority: 0 > 1 > 2. When counter == STARVE_MAX: 0 > 2 > 1.
  - On a grant g:
    - latch o_csr_addr = reqg_addr, o_csr_ren = reqg_ren, o_csr_wen = reqg_wen, o_csr_wdata = reqg_wdata.
    - owner = g; lock = reqg_lock.
    - go to ACCESS.
  - No eligible valid: stay in IDLE, all o_csr_* enables 0.
- ACCESS (enables high exactly one cycle):
  - capture i_csr_rdata into reqg_rdata.
  - set reqg_ack <= 1.
  - clear o_csr_ren/o_csr_wen.
  - go to RESP.
- RESP:
  - reqg_ack is high for this one cycle; the requester's valid is ignored.
  - next cycle: ack = 0, state = IDLE.
- Throughput and latency:
  - valid sampled in cycle T, enables in T+1, ack in T+2.
  - earliest next sample T+3, i.e. 3 cycles per access.
- reqN_rdata holds its value until that requester's next ack.
- ren=1 and wen=1 together: a single access; rdata returns the pre-write value (CSR file read-before-write).
- ren=0 and wen=0 with valid=1: a no-op access; the CSR file is not enabled, the ack is still issued and rdata is unchanged.
- Lock:
  - A locked owner blocks all others, including requester 0.
  - The lock is evaluated only in IDLE.
  - A locked owner with valid=0 and lock=1 keeps the port and the arbiter idles.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each grant to requester 1 while req2_valid=1.
  - Clears on a grant to requester 2, or when req2_valid=0 in IDLE.
- Only the granted requester's fields ever reach o_csr_*. Non-granted requesters see no ack.
- o_owner updates at grant and holds the grantee until the next grant.

Decomposition:
- defines.v additions:
  - `CSR_ADDR_W (12)
  - `BUS_64 (existing)
  - owner encodings `CSRARB_EXC = 2'd0, `CSRARB_EXE = 2'd1, `CSRARB_IRQ = 2'd2, `CSRARB_NONE = 2'd3
  - FSM state constants
- Sub-module: csr_arb_pick, combinational.
  - Inputs: valids, lock, owner, promote.
  - Outputs: grant valid and grant index.
  - Keeps the priority/lock rule unit-testable in isolation.

Test Plan:
- Single read: req1 read of 0x300 with the CSR file returning 0x8 -> o_csr_ren high in T+1 only; req1_ack in T+2; req1_rdata = 0x8; o_owner = 1.
- Simultaneous requests: req0 writes 0x341 = 0x80000100 while req1 reads 0x305 in the same cycle -> req0 is served first (wen at T+1), then req1 (ren at T+4), with acks at T+2 and T+5.
- Lock sequence: req0 locks for 5 accesses (0x341 W, 0x342 W, 0x305 R, 0x300 R, 0x300 W) while req1 is held valid -> req1 gets no grant until req0 drops lock; req1 then acks 3 cycles after the lock drops.
- Starvation: req1 and req2 valid continuously with STARVE_MAX = 8 -> after 8 grants to req1, the 9th grant goes to req2 and the counter returns to 0.
- Read+write same access: req1 with ren=1, wen=1, wdata = 0x1888, CSR 0x300 old value 0x0 -> req1_rdata = 0x0 and the CSR file is written 0x1888 in a single ACCESS cycle.
- Reset mid-access: assert rst_n=0 during ACCESS -> o_csr_wen and all acks are 0 immediately (asynchronous), lock is cleared and o_owner = 3; after release, a pending req2 is granted normally.
